// File: rtl/acc_window_if.sv
// ---------------------------------------------------------------------------
// Module      : acc_window_if
// Description : R/D valid-data stream bundle for the windowed accumulator.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface acc_window_if #(
    parameter int N    = 16,
    parameter int W    = 32,
    parameter int CNTW = 4
);
    logic            EN;
    logic            R_IN;
    logic [N-1:0]    D_IN;
    logic            FLUSH;
    logic            R_OUT;
    logic [W-1:0]    D_OUT;
    logic [CNTW-1:0] N_OUT;

    modport master (
        output EN, R_IN, D_IN, FLUSH,
        input  R_OUT, D_OUT, N_OUT
    );

    modport slave (
        input  EN, R_IN, D_IN, FLUSH,
        output R_OUT, D_OUT, N_OUT
    );
endinterface

`default_nettype wire

// File: rtl/acc_window.sv
// ---------------------------------------------------------------------------
// Module      : acc_window
// Description : Sums every L accepted words (or fewer on FLUSH), one result per window.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module acc_window #(
    parameter int N    = 16,
    parameter int W    = 32,
    parameter int L    = 8,
    parameter int CNTW = $clog2(L + 1)
) (
    input  wire         CLK,
    input  wire         RST,
    acc_window_if.slave io_bus
);

    localparam logic [0:0]      c_S_EMPTY   = 1'b0;
    localparam logic [0:0]      c_S_FILLING = 1'b1;
    localparam logic [CNTW-1:0] c_LAST      = CNTW'(L - 1);

    logic [W-1:0]    r_acc;
    logic [CNTW-1:0] r_cnt;
    logic            r_rout;
    logic [W-1:0]    r_dout;
    logic [CNTW-1:0] r_nout;

    logic [0:0]      w_state;
    logic [W-1:0]    w_sum;
    logic [W-1:0]    w_acc_nxt;
    logic [CNTW-1:0] w_cnt_nxt;
    logic            w_emit;
    logic [W-1:0]    w_dout_nxt;
    logic [CNTW-1:0] w_nout_nxt;

    // State is implied by the word count rather than held separately.
    assign w_state = (r_cnt == '0) ? c_S_EMPTY : c_S_FILLING;
    assign w_sum   = r_acc + W'(io_bus.D_IN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_rout <= 1'b0;
            r_dout <= '0;
            r_nout <= '0;
        end else if (io_bus.EN) begin
            r_acc  <= w_acc_nxt;
            r_cnt  <= w_cnt_nxt;
            r_rout <= w_emit;
            r_dout <= w_dout_nxt;
            r_nout <= w_nout_nxt;
        end
    end

    always_comb begin
        w_acc_nxt  = r_acc;
        w_cnt_nxt  = r_cnt;
        w_emit     = 1'b0;
        w_dout_nxt = r_dout;
        w_nout_nxt = r_nout;
        if (io_bus.R_IN) begin
            if ((r_cnt == c_LAST) || io_bus.FLUSH) begin
                // cnt+1 equals L on a full window, so one expression covers both closes.
                w_emit     = 1'b1;
                w_dout_nxt = w_sum;
                w_nout_nxt = r_cnt + 1'b1;
                w_acc_nxt  = '0;
                w_cnt_nxt  = '0;
            end else begin
                w_acc_nxt  = w_sum;
                w_cnt_nxt  = r_cnt + 1'b1;
            end
        end else if (io_bus.FLUSH && (w_state == c_S_FILLING)) begin
            w_emit     = 1'b1;
            w_dout_nxt = r_acc;
            w_nout_nxt = r_cnt;
            w_acc_nxt  = '0;
            w_cnt_nxt  = '0;
        end
    end

    always_comb begin
        io_bus.R_OUT = r_rout;
        io_bus.D_OUT = r_dout;
        io_bus.N_OUT = r_nout;
    end

endmodule

`default_nettype wire

// File: tb/tb_acc_window.sv
// ---------------------------------------------------------------------------
// Module      : tb_acc_window
// Description : Directed self-checking bench for acc_window (L=4, W=32 and W=16).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_acc_window;

    logic CLK;
    logic RST;
    int   r_errors;
    int   r_checks;

    acc_window_if #(.N(16), .W(32), .CNTW(3)) bus32 ();
    acc_window_if #(.N(16), .W(16), .CNTW(3)) bus16 ();

    acc_window #(.N(16), .W(32), .L(4)) u_dut32 (.CLK(CLK), .RST(RST), .io_bus(bus32));
    acc_window #(.N(16), .W(16), .L(4)) u_dut16 (.CLK(CLK), .RST(RST), .io_bus(bus16));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic r, input logic f, input logic [15:0] d);
        bus32.EN = en; bus32.R_IN = r; bus32.FLUSH = f; bus32.D_IN = d;
        bus16.EN = en; bus16.R_IN = r; bus16.FLUSH = f; bus16.D_IN = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect32(input string tag, input logic r, input logic [31:0] d, input logic [2:0] n);
        check({tag, ".r"}, {31'd0, bus32.R_OUT}, {31'd0, r});
        check({tag, ".d"}, bus32.D_OUT, d);
        check({tag, ".n"}, {29'd0, bus32.N_OUT}, {29'd0, n});
    endtask

    task automatic word(input logic [15:0] d);
        drive(1'b1, 1'b1, 1'b0, d);
        tick();
    endtask

    initial begin
        r_errors = 0;
        r_checks = 0;
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'd0);
        tick(); tick();
        expect32("reset", 1'b0, 32'd0, 3'd0);
        check("reset16.d", {16'd0, bus16.D_OUT}, 32'd0);
        RST = 1'b0;

        // Full window 1..4
        for (int i = 1; i <= 4; i++) begin
            word(16'(i));
            if (i < 4) check("full.pre", {31'd0, bus32.R_OUT}, 32'd0);
        end
        expect32("full", 1'b1, 32'd10, 3'd4);
        drive(1'b1, 1'b0, 1'b0, 16'd0); tick();
        expect32("full.hold", 1'b0, 32'd10, 3'd4);

        // Back-to-back windows 1..8
        for (int i = 1; i <= 8; i++) begin
            word(16'(i));
            if (i == 4)      expect32("b2b.w1", 1'b1, 32'd10, 3'd4);
            else if (i == 8) expect32("b2b.w2", 1'b1, 32'd26, 3'd4);
            else             check("b2b.gap", {31'd0, bus32.R_OUT}, 32'd0);
        end

        // Partial flushes
        word(16'd5); word(16'd7);
        drive(1'b1, 1'b0, 1'b1, 16'd0); tick();
        expect32("flush.idle", 1'b1, 32'd12, 3'd2);
        word(16'd5); word(16'd7);
        drive(1'b1, 1'b1, 1'b1, 16'd9); tick();
        expect32("flush.word", 1'b1, 32'd21, 3'd3);
        drive(1'b1, 1'b0, 1'b1, 16'd0); tick();
        expect32("flush.empty", 1'b0, 32'd21, 3'd3);

        // EN stall mid-window and while R_OUT is high
        word(16'd1); word(16'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'd100); tick();
        end
        check("stall.mid", {31'd0, bus32.R_OUT}, 32'd0);
        word(16'd3); word(16'd4);
        expect32("stall.sum", 1'b1, 32'd10, 3'd4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 16'd100); tick();
            check("stall.rout", {31'd0, bus32.R_OUT}, 32'd1);
        end
        drive(1'b1, 1'b0, 1'b0, 16'd0); tick();
        expect32("stall.after", 1'b0, 32'd10, 3'd4);

        // Wrap in W=16 copy, no wrap in W=32
        for (int i = 0; i < 4; i++) word(16'hFFFF);
        check("wrap16.d", {16'd0, bus16.D_OUT}, 32'h0000_FFFC);
        check("wrap16.r", {31'd0, bus16.R_OUT}, 32'd1);
        expect32("wrap32", 1'b1, 32'h0003_FFFC, 3'd4);

        // Bubbles between words
        word(16'd1);
        drive(1'b1, 1'b0, 1'b0, 16'd50); tick();
        word(16'd2);
        drive(1'b1, 1'b0, 1'b0, 16'd50); tick();
        drive(1'b1, 1'b0, 1'b0, 16'd50); tick();
        check("bubble.gap", {31'd0, bus32.R_OUT}, 32'd0);
        word(16'd3); word(16'd4);
        expect32("bubble", 1'b1, 32'd10, 3'd4);

        // Reset mid-window discards the partial sum
        word(16'd3); word(16'd3);
        RST = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'd3); tick();
        RST = 1'b0;
        expect32("rst.mid", 1'b0, 32'd0, 3'd0);
        for (int i = 0; i < 4; i++) word(16'd1);
        expect32("rst.after", 1'b1, 32'd4, 3'd4);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule

`default_nettype wire
